// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// buffering with PC tags, and redirect handling with in-flight response discard.
module instr_fetch_unit #(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    ILEN     = 32,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] PC_START = '0,
   parameter int unsigned    PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_en,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_addr,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
);

   localparam int unsigned     CW      = $clog2(DEPTH) + 1;
   localparam int unsigned     PW      = $clog2(DEPTH);
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] STEP_C  = XLEN'(PC_STEP);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      FLUSH
   } state_e;

   state_e          state_q;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   out_q, out_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [ILEN-1:0] instr_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q    [DEPTH];

   logic            accept;
   logic            pop;
   logic            resp;
   logic            push;
   logic [XLEN-1:0] redirect_pc;
   logic            unused_redirect_lsbs;

   assign redirect_pc          = {redirect_addr[XLEN-1:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_addr[1:0];

   // Credits cover both in-flight requests and buffered entries, so every
   // response that is not being discarded is guaranteed a free slot.
   assign imem_req_valid = !rst && (state_q == FETCH) && fetch_en && !redirect_valid &&
                           (({1'b0, out_q} + {1'b0, count_q}) < DEPTH_C);
   assign imem_req_addr  = fetch_pc_q;

   assign instr_valid = !rst && (count_q != '0);
   assign instr       = instr_mem_q[head_q];
   assign instr_pc    = pc_mem_q[head_q];

   assign accept = imem_req_valid && imem_req_ready;
   assign pop    = instr_valid && instr_ready;
   assign resp   = imem_resp_valid && !rst;
   assign push   = resp && !redirect_valid && (discard_q == '0);

   always_comb begin
      out_d      = out_q + CW'(accept) - CW'(resp);
      fetch_pc_d = accept ? fetch_pc_q + STEP_C : fetch_pc_q;
      resp_pc_d  = push ? resp_pc_q + STEP_C : resp_pc_q;
      discard_d  = (resp && (discard_q != '0)) ? discard_q - CW'(1) : discard_q;
      head_d     = pop ? head_q + PW'(1) : head_q;
      tail_d     = push ? tail_q + PW'(1) : tail_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      // The pop above is still honoured; the buffer is then emptied.
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         discard_d  = out_d;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= PC_START;
         resp_pc_q  <= PC_START;
         out_q      <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         if (redirect_valid) begin
            if (discard_d != '0) state_q <= FLUSH;
            else                 state_q <= fetch_en ? FETCH : IDLE;
         end else begin
            case (state_q)
               IDLE:    if (fetch_en) state_q <= FETCH;
               FETCH:   if (!fetch_en) state_q <= IDLE;
               FLUSH:   if (discard_d == '0) state_q <= fetch_en ? FETCH : IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // NOTE: buffer storage has no reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[tail_q] <= imem_resp_data;
         pc_mem_q[tail_q]    <= resp_pc_q;
      end
   end

endmodule
